daq_event_builder: RTL

Sequences per-channel digitizer readout into the AMC13 DAQ link event interface (valid/header/trailer/64-bit data, ready, almost-full). On each accepted trigger it emits one event: a header word, then one sub-header plus payload per enabled channel in ascending channel order, then a trailer. It sits between the channel readout FIFOs and the DAQ link in the 125 MHz domain and is the sole master of the link's event-data port.

---
 rtl/daq_pkg.sv | 32 +++
 rtl/daq_next_chan.sv | 30 +++
 rtl/daq_event_builder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/daq_pkg.sv
// Shared types, word markers and event-word packing for the DAQ event builder.
package daq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HEADER    = 3'd1,
    ST_CHAN_HDR  = 3'd2,
    ST_CHAN_DATA = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_TRAILER   = 3'd5
  } daq_state_e;

  localparam logic [7:0] HDR_MARK  = 8'h50;
  localparam logic [7:0] CHDR_MARK = 8'hC0;
  localparam logic [7:0] TRL_MARK  = 8'hA0;

  // Event header: marker, event number, reserved, source ID, reserved.
  function automatic logic [63:0] pack_header(input logic [23:0] evn, input logic [11:0] src);
    return {HDR_MARK, evn, 12'h000, src, 8'h00};
  endfunction

  // Channel sub-header: marker, event number, reserved, channel index.
  function automatic logic [63:0] pack_chan_hdr(input logic [23:0] evn, input logic [2:0] ch);
    return {CHDR_MARK, evn, 24'h000000, 4'h0, 1'b0, ch};
  endfunction

  // Event trailer: marker, word count including the trailer, truncation mask.
  function automatic logic [63:0] pack_trailer(input logic [23:0] len, input logic [7:0] trunc);
    return {TRL_MARK, len, 16'h0000, trunc, 8'h00};
  endfunction

endpackage

// File: rtl/daq_next_chan.sv
// Priority finder: lowest enabled channel, either from channel 0 (start of
// event) or strictly above the channel currently being read.
module daq_next_chan
  import daq_pkg::*;
#(
  parameter int NUM_CHAN = 5
) (
  input  logic [NUM_CHAN-1:0] en,
  input  logic [2:0]          cur,
  input  logic                from_start,
  output logic [2:0]          nxt,
  output logic                none
);

  logic [NUM_CHAN-1:0] cand_s;

  // Mark eligible channels, then keep the lowest one by scanning downwards.
  always_comb begin
    cand_s = '0;
    nxt    = 3'd0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      cand_s[i] = en[i] & (from_start | (3'(i) > cur));
    end
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      nxt = cand_s[i] ? 3'(i) : nxt;
    end
    none = ~|cand_s;
  end

endmodule

// File: rtl/daq_event_builder.sv
// Builds AMC13 DAQ events from per-channel readout streams: header, one
// sub-header plus payload per enabled channel (ascending), then a trailer.
module daq_event_builder
  import daq_pkg::*;
#(
  parameter int          NUM_CHAN        = 5,
  parameter logic [11:0] SOURCE_ID       = 12'h000,
  parameter int          MAX_CHAN_WORDS  = 4096,
  parameter int          TRIG_FIFO_DEPTH = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trigger,
  input  logic [NUM_CHAN-1:0]      chan_enable,
  input  logic [64*NUM_CHAN-1:0]   chan_tdata,
  input  logic [NUM_CHAN-1:0]      chan_tvalid,
  input  logic [NUM_CHAN-1:0]      chan_tlast,
  output logic [NUM_CHAN-1:0]      chan_tready,
  output logic                     daq_valid,
  output logic                     daq_header,
  output logic                     daq_trailer,
  output logic [63:0]              daq_data,
  input  logic                     daq_ready,
  input  logic                     daq_almost_full,
  output logic [23:0]              event_num,
  output logic                     busy,
  output logic                     trig_overflow
);

  localparam int PEND_W = 4;
  localparam int WCNT_W = $clog2(MAX_CHAN_WORDS) + 1;
  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(TRIG_FIFO_DEPTH);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_CHAN_WORDS - 1);

  daq_state_e state_r, state_s, adv_state_s;

  logic [NUM_CHAN-1:0] en_q_r;
  logic [2:0]          ch_r;
  logic [23:0]         len_r;
  logic [23:0]         evn_r;
  logic [23:0]         event_num_r;
  logic [WCNT_W-1:0]   wcnt_r;
  logic [7:0]          trunc_r;
  logic [PEND_W-1:0]   pending_r;
  logic                ovf_r;

  logic                stall_s;
  logic                chan_valid_s;
  logic                chan_last_s;
  logic [63:0]         chan_data_s;
  logic [2:0]          nc_ch_s;
  logic                nc_none_s;
  logic                trig_acc_s;
  logic                trig_drop_s;

  logic                daq_valid_s;
  logic                daq_header_s;
  logic                daq_trailer_s;
  logic [63:0]         daq_data_s;
  logic [NUM_CHAN-1:0] tready_s;
  logic                hdr_emit_s;
  logic                chdr_emit_s;
  logic                xfer_s;
  logic                trl_emit_s;
  logic                latch_en_s;
  logic                load_ch_s;
  logic                trunc_set_s;

  assign stall_s      = ~daq_ready | daq_almost_full;
  assign chan_valid_s = chan_tvalid[ch_r];
  assign chan_last_s  = chan_tlast[ch_r];
  assign chan_data_s  = chan_tdata[{ch_r, 6'b000000} +: 64];
  assign trig_acc_s   = trigger & (pending_r != PEND_FULL);
  assign trig_drop_s  = trigger & (pending_r == PEND_FULL);

  // In HEADER the search starts at channel 0; afterwards it looks above ch_r.
  daq_next_chan #(.NUM_CHAN(NUM_CHAN)) u_next_chan (
    .en         (en_q_r),
    .cur        (ch_r),
    .from_start (state_r == ST_HEADER),
    .nxt        (nc_ch_s),
    .none       (nc_none_s)
  );

  assign adv_state_s = nc_none_s ? ST_TRAILER : ST_CHAN_HDR;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and link/channel handshake outputs.
  always_comb begin
    state_s       = state_r;
    daq_valid_s   = 1'b0;
    daq_header_s  = 1'b0;
    daq_trailer_s = 1'b0;
    daq_data_s    = 64'h0;
    tready_s      = '0;
    hdr_emit_s    = 1'b0;
    chdr_emit_s   = 1'b0;
    xfer_s        = 1'b0;
    trl_emit_s    = 1'b0;
    latch_en_s    = 1'b0;
    load_ch_s     = 1'b0;
    trunc_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pending_r != '0) begin
          latch_en_s = 1'b1;
          state_s    = ST_HEADER;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (!stall_s) begin
          daq_valid_s  = 1'b1;
          daq_header_s = 1'b1;
          daq_data_s   = pack_header(evn_r, SOURCE_ID);
          hdr_emit_s   = 1'b1;
          load_ch_s    = ~nc_none_s;
          state_s      = adv_state_s;
        end else begin
          state_s = ST_HEADER;
        end
      end
      ST_CHAN_HDR: begin
        if (!stall_s) begin
          daq_valid_s = 1'b1;
          daq_data_s  = pack_chan_hdr(evn_r, ch_r);
          chdr_emit_s = 1'b1;
          state_s     = ST_CHAN_DATA;
        end else begin
          state_s = ST_CHAN_HDR;
        end
      end
      ST_CHAN_DATA: begin
        // Zero-latency pass-through of the selected channel.
        tready_s[ch_r] = ~stall_s;
        daq_valid_s    = chan_valid_s & ~stall_s;
        daq_data_s     = chan_data_s;
        xfer_s         = chan_valid_s & ~stall_s;
        if (xfer_s && chan_last_s) begin
          load_ch_s = ~nc_none_s;
          state_s   = adv_state_s;
        end else if (xfer_s && (wcnt_r == WCNT_LAST)) begin
          trunc_set_s = 1'b1;
          state_s     = ST_DRAIN;
        end else begin
          state_s = ST_CHAN_DATA;
        end
      end
      ST_DRAIN: begin
        // Discard the rest of an over-long channel; the link is not involved.
        tready_s[ch_r] = 1'b1;
        if (chan_valid_s && chan_last_s) begin
          load_ch_s = ~nc_none_s;
          state_s   = adv_state_s;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_TRAILER: begin
        if (!stall_s) begin
          daq_valid_s   = 1'b1;
          daq_trailer_s = 1'b1;
          daq_data_s    = pack_trailer(len_r + 24'd1, trunc_r);
          trl_emit_s    = 1'b1;
          state_s       = ST_IDLE;
        end else begin
          state_s = ST_TRAILER;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Per-event context: enable snapshot, current channel, word counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q_r  <= '0;
      ch_r    <= 3'd0;
      len_r   <= 24'd0;
      wcnt_r  <= '0;
      trunc_r <= 8'h00;
    end else begin
      if (latch_en_s) en_q_r <= chan_enable;
      if (load_ch_s) ch_r <= nc_ch_s;
      if (hdr_emit_s) begin
        len_r <= 24'd1;
      end else if (chdr_emit_s || xfer_s) begin
        len_r <= len_r + 24'd1;
      end
      if (chdr_emit_s) begin
        wcnt_r <= '0;
      end else if (xfer_s) begin
        wcnt_r <= wcnt_r + WCNT_W'(1);
      end
      if (trl_emit_s) begin
        trunc_r <= 8'h00;
      end else if (trunc_set_s) begin
        trunc_r <= trunc_r | (8'h01 << ch_r);
      end
    end
  end

  // Event numbering: evn_r is the number the next event will carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      evn_r       <= 24'd1;
      event_num_r <= 24'd0;
    end else if (trl_emit_s) begin
      evn_r       <= evn_r + 24'd1;
      event_num_r <= evn_r;
    end else begin
      evn_r       <= evn_r;
      event_num_r <= event_num_r;
    end
  end

  // Pending-trigger counter and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= '0;
      ovf_r     <= 1'b0;
    end else begin
      case ({trig_acc_s, hdr_emit_s})
        2'b10:   pending_r <= pending_r + PEND_W'(1);
        2'b01:   pending_r <= pending_r - PEND_W'(1);
        default: pending_r <= pending_r;
      endcase
      if (trig_drop_s) ovf_r <= 1'b1;
    end
  end

  assign daq_valid     = daq_valid_s;
  assign daq_header    = daq_header_s;
  assign daq_trailer   = daq_trailer_s;
  assign daq_data      = daq_data_s;
  assign chan_tready   = tready_s;
  assign event_num     = event_num_r;
  assign trig_overflow = ovf_r;
  assign busy          = (state_r != ST_IDLE) | (pending_r != '0);

endmodule
